// File: rtl/mem_write_packer_pkg.sv
// Shared types and sizing helpers for the memory write packer.
package mem_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_RSP = 2'd3
  } mem_wr_state_t;

  // Default-configuration geometry (512-bit lines of 32-bit elements).
  localparam int EPL               = 512 / 32;
  localparam int LP_LOG_EPL        = $clog2(EPL);
  localparam int LP_LOG_LINE_BYTES = $clog2(512 / 8);

  // Elements per line for an arbitrary configuration.
  function automatic int epl_of(input int data_w, input int elem_w);
    return data_w / elem_w;
  endfunction

  // Width able to hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mem_write_packer_if.sv
// Element input stream and line write request/response bundle.
interface mem_write_packer_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_ELEM_WIDTH       = 32,
  parameter int C_INDEX_WIDTH      = 32
);
  logic                          elem_valid;
  logic                          elem_ready;
  logic [C_INDEX_WIDTH-1:0]      elem_index;
  logic [C_ELEM_WIDTH-1:0]       elem_value;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data;
  logic                          wr_rsp;

  // Packer side.
  modport master (
    input  elem_valid, elem_index, elem_value, wr_ready, wr_rsp,
    output elem_ready, wr_valid, wr_addr, wr_data
  );

  // Producer / write-master side.
  modport slave (
    output elem_valid, elem_index, elem_value, wr_ready, wr_rsp,
    input  elem_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/mem_axi_control_counter.sv
// Up/down counter with synchronous clear; decrement at zero is ignored.
module mem_axi_control_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             incr,
  input  logic             decr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             dec_ok;

  // Next count: clear wins, then net of increment and non-underflowing decrement.
  always_comb begin
    dec_ok  = decr && (count_q != '0);
    count_d = count_q;
    if (clr)                 count_d = INIT;
    else if (incr && !dec_ok) count_d = count_q + WIDTH'(1);
    else if (!incr && dec_ok) count_d = count_q - WIDTH'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= INIT;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mem_write_packer.sv
// Packs index-ordered sparse elements into full memory lines and tracks
// write responses until the pass is fully acknowledged.
module mem_write_packer
  import mem_write_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 64,
  parameter int          C_M_AXI_DATA_WIDTH = 512,
  parameter int          C_ELEM_WIDTH       = 32,
  parameter int          C_INDEX_WIDTH      = 32,
  parameter int          C_MAX_OUTSTANDING  = 32,
  parameter int unsigned C_FILL_VALUE       = 0
) (
  input  logic                acc_clk,
  input  logic                acc_rst_n,
  input  logic                start,
  input  logic                flush,
  input  logic                complete,
  mem_write_packer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err_order,
  output logic [31:0]         lines_written
);
  localparam int AW       = C_M_AXI_ADDR_WIDTH;
  localparam int DW       = C_M_AXI_DATA_WIDTH;
  localparam int EW       = C_ELEM_WIDTH;
  localparam int IW       = C_INDEX_WIDTH;
  localparam int L_EPL    = epl_of(DW, EW);
  localparam int L_LOG_EPL = $clog2(L_EPL);
  localparam int L_LOG_LB = $clog2(DW / 8);
  localparam int LINE_W   = IW - L_LOG_EPL;
  localparam int CW       = cnt_width(C_MAX_OUTSTANDING);
  localparam logic [EW-1:0] FILL_ELEM = EW'(C_FILL_VALUE);
  localparam logic [DW-1:0] FILL_LINE = {L_EPL{FILL_ELEM}};

  mem_wr_state_t     state_q, state_d;
  logic              open_q, open_d, full_q, full_d;
  logic              has_last_q, has_last_d, err_q, err_d, done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [DW-1:0]     buf_q, buf_d, out_data_q, out_data_d;
  logic [AW-1:0]     out_addr_q, out_addr_d;
  logic [IW-1:0]     last_q, last_d;
  logic [31:0]       lines_q, lines_d;
  logic [CW-1:0]     outst;

  // Combinational working copies of the open line.
  logic              nopen, nfull, push, cnt_clr;
  logic [LINE_W-1:0] nline, push_line;
  logic [DW-1:0]     nbuf, push_data;

  logic              wr_fire, out_free, elem_fire, ord_ok, drain_now;
  logic [LINE_W-1:0] e_line;
  logic [L_LOG_EPL-1:0] e_slot;

  function automatic logic [AW-1:0] line_addr(input logic [LINE_W-1:0] ln);
    return AW'(ln) << L_LOG_LB;
  endfunction

  // A held line only counts as drained once it actually handshakes, so the
  // outstanding limit can stall the output register without losing it.
  assign bus.wr_valid   = out_valid_q && (outst < CW'(C_MAX_OUTSTANDING));
  assign wr_fire        = bus.wr_valid && bus.wr_ready;
  assign out_free       = !out_valid_q || wr_fire;
  assign bus.elem_ready = (state_q == ST_RUN) && out_free;
  assign elem_fire      = bus.elem_valid && bus.elem_ready;
  assign e_line         = bus.elem_index[IW-1:L_LOG_EPL];
  assign e_slot         = bus.elem_index[L_LOG_EPL-1:0];
  assign ord_ok         = !has_last_q || (bus.elem_index > last_q);
  assign drain_now      = (state_q == ST_RUN && flush) || (state_q == ST_DRAIN);

  // Line assembly, output register loading and pass sequencing.
  always_comb begin
    state_d     = state_q;
    nbuf        = buf_q;
    nline       = line_q;
    nopen       = open_q;
    nfull       = full_q;
    push        = 1'b0;
    push_line   = line_q;
    push_data   = buf_q;
    has_last_d  = has_last_q;
    last_d      = last_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    out_valid_d = out_valid_q && !wr_fire;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    lines_d     = wr_fire ? lines_q + 32'd1 : lines_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_RUN;
        nopen      = 1'b0;
        nfull      = 1'b0;
        has_last_d = 1'b0;
        last_d     = '0;
        err_d      = 1'b0;
        lines_d    = '0;
        cnt_clr    = 1'b1;
      end
      ST_RUN, ST_DRAIN: begin
        if (elem_fire) begin
          if (!ord_ok) err_d = 1'b1;
          else begin
            has_last_d = 1'b1;
            last_d     = bus.elem_index;
            if (!(nopen && e_line == nline)) begin
              if (nopen) begin
                push      = 1'b1;
                push_line = nline;
                push_data = nbuf;
              end
              nbuf  = FILL_LINE;
              nline = e_line;
              nopen = 1'b1;
              nfull = 1'b0;
            end
            nbuf[int'(e_slot)*EW +: EW] = bus.elem_value;
            if (&e_slot) nfull = 1'b1;
          end
        end
        // A full line (or any line when draining) leaves as soon as the
        // output register is free; a full line that collided with a
        // line-change push waits one cycle here.
        if (nopen && !push && out_free && (nfull || drain_now)) begin
          push      = 1'b1;
          push_line = nline;
          push_data = nbuf;
          nopen     = 1'b0;
          nfull     = 1'b0;
        end
        if (push) begin
          out_valid_d = 1'b1;
          out_addr_d  = line_addr(push_line);
          out_data_d  = push_data;
        end
        if (state_q == ST_RUN && flush)                       state_d = ST_DRAIN;
        else if (state_q == ST_DRAIN && !nopen && !out_valid_d) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: if (outst == '0 && complete) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    buf_d  = nbuf;
    line_d = nline;
    open_d = nopen;
    full_d = nfull;
  end

  // State registers.
  always_ff @(posedge acc_clk or negedge acc_rst_n) begin
    if (!acc_rst_n) begin
      state_q     <= ST_IDLE;
      open_q      <= 1'b0;
      full_q      <= 1'b0;
      has_last_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      line_q      <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      last_q      <= '0;
      lines_q     <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      full_q      <= full_d;
      has_last_q  <= has_last_d;
      err_q       <= err_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      line_q      <= line_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      last_q      <= last_d;
      lines_q     <= lines_d;
    end
  end

  mem_axi_control_counter #(
    .WIDTH (CW),
    .INIT  ({CW{1'b0}})
  ) u_outstanding (
    .clk   (acc_clk),
    .rst_n (acc_rst_n),
    .clr   (cnt_clr),
    .incr  (wr_fire),
    .decr  (bus.wr_rsp),
    .count (outst)
  );

  assign bus.wr_addr    = out_addr_q;
  assign bus.wr_data    = out_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err_order      = err_q;
  assign lines_written  = lines_q;
endmodule

// File: tb/tb_mem_write_packer.sv
// Directed bench: table-driven passes on a 128-bit/32-bit packer plus
// backpressure, reset and outstanding-limit sequences.
module tb_mem_write_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic complete = 1'b1;
  logic start_a = 1'b0, flush_a = 1'b0, busy_a, done_a, err_a;
  logic start_b = 1'b0, flush_b = 1'b0, busy_b, done_b, err_b;
  logic [31:0] lw_a, lw_b;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [63:0]  qa_addr[$], qb_addr[$];
  logic [127:0] qa_data[$], qb_data[$];

  always #5 clk = ~clk;

  mem_write_packer_if #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(128),
                        .C_ELEM_WIDTH(32), .C_INDEX_WIDTH(32)) bus_a ();
  mem_write_packer_if #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(128),
                        .C_ELEM_WIDTH(32), .C_INDEX_WIDTH(32)) bus_b ();

  mem_write_packer #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(128), .C_ELEM_WIDTH(32),
                     .C_INDEX_WIDTH(32), .C_MAX_OUTSTANDING(32), .C_FILL_VALUE(0)) dut_a (
    .acc_clk(clk), .acc_rst_n(rst_n), .start(start_a), .flush(flush_a), .complete(complete),
    .bus(bus_a), .busy(busy_a), .done(done_a), .err_order(err_a), .lines_written(lw_a));

  mem_write_packer #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(128), .C_ELEM_WIDTH(32),
                     .C_INDEX_WIDTH(32), .C_MAX_OUTSTANDING(2), .C_FILL_VALUE(0)) dut_b (
    .acc_clk(clk), .acc_rst_n(rst_n), .start(start_b), .flush(flush_b), .complete(complete),
    .bus(bus_b), .busy(busy_b), .done(done_b), .err_order(err_b), .lines_written(lw_b));

  // Record handshakes just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (bus_a.wr_valid && bus_a.wr_ready) begin
      qa_addr.push_back(bus_a.wr_addr);
      qa_data.push_back(bus_a.wr_data);
    end
    if (bus_b.wr_valid && bus_b.wr_ready) begin
      qb_addr.push_back(bus_b.wr_addr);
      qb_data.push_back(bus_b.wr_data);
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  typedef struct packed {
    logic [3:0]         n;
    logic [7:0][31:0]   idx;
    logic [7:0][31:0]   val;
    logic [1:0]         nl;
    logic [1:0][63:0]   addr;
    logic [1:0][127:0]  data;
    logic               err;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // following the accepting rising edge.
  task automatic send_a(input logic [31:0] idx, input logic [31:0] val);
    int b = 0;
    bus_a.elem_valid = 1'b1; bus_a.elem_index = idx; bus_a.elem_value = val;
    #4;
    while (!bus_a.elem_ready && b < 100) begin @(negedge clk); #4; b++; end
    if (b >= 100) timeout("send_a");
    @(negedge clk);
    bus_a.elem_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] idx, input logic [31:0] val);
    int b = 0;
    bus_b.elem_valid = 1'b1; bus_b.elem_index = idx; bus_b.elem_value = val;
    #4;
    while (!bus_b.elem_ready && b < 100) begin @(negedge clk); #4; b++; end
    if (b >= 100) timeout("send_b");
    @(negedge clk);
    bus_b.elem_valid = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input bit stall);
    int b;
    int d0;
    qa_addr.delete(); qa_data.delete();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    chk("start_busy", busy_a, 1'b1);
    chk("start_err_clr", err_a, 1'b0);
    chk("start_lw_clr", lw_a, 32'd0);
    if (stall) bus_a.wr_ready = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      if (stall && i == 4) begin
        bus_a.elem_valid = 1'b1; bus_a.elem_index = v.idx[i]; bus_a.elem_value = v.val[i];
        for (int k = 0; k < 10; k++) begin
          #1;
          chk("bp_elem_ready", bus_a.elem_ready, 1'b0);
          chk("bp_wr_valid", bus_a.wr_valid, 1'b1);
          chk("bp_addr", bus_a.wr_addr, v.addr[0]);
          chk("bp_data", bus_a.wr_data, v.data[0]);
          @(negedge clk);
        end
        bus_a.wr_ready = 1'b1;
      end
      send_a(v.idx[i], v.val[i]);
    end
    flush_a = 1'b1; @(negedge clk); flush_a = 1'b0;
    b = 0;
    while (qa_addr.size() < int'(v.nl) && b < 50) begin @(negedge clk); b++; end
    if (b >= 50) timeout("lines");
    d0 = done_cnt_a;
    repeat (3) @(negedge clk);
    chk("no_early_done", done_cnt_a - d0, 0);
    chk("err_order", err_a, v.err);
    for (int k = 0; k < int'(v.nl); k++) begin
      bus_a.wr_rsp = 1'b1; @(negedge clk); bus_a.wr_rsp = 1'b0; @(negedge clk);
    end
    b = 0;
    while (done_cnt_a == d0 && b < 20) begin @(negedge clk); b++; end
    if (b >= 20) timeout("done");
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt_a - d0, 1);
    chk("busy_end", busy_a, 1'b0);
    chk("lines_written", lw_a, 128'(v.nl));
    chk("line_count", qa_addr.size(), 128'(v.nl));
    for (int k = 0; k < int'(v.nl) && k < qa_addr.size(); k++) begin
      chk("line_addr", qa_addr[k], v.addr[k]);
      chk("line_data", qa_data[k], v.data[k]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    for (int k = 0; k < 5; k++) vec[k] = '0;
    // dense 0..7
    vec[0].n = 4'd8; vec[0].nl = 2'd2; vec[0].addr[0] = 64'h0; vec[0].addr[1] = 64'h10;
    for (int i = 0; i < 8; i++) begin vec[0].idx[i] = i; vec[0].val[i] = 32'h10 + i; end
    vec[0].data[0] = 128'h00000013_00000012_00000011_00000010;
    vec[0].data[1] = 128'h00000017_00000016_00000015_00000014;
    // sparse 1, 6
    vec[1].n = 4'd2; vec[1].nl = 2'd2; vec[1].addr[0] = 64'h0; vec[1].addr[1] = 64'h10;
    vec[1].idx[0] = 1; vec[1].val[0] = 32'hAA; vec[1].idx[1] = 6; vec[1].val[1] = 32'hBB;
    vec[1].data[0] = 128'h00000000_00000000_000000AA_00000000;
    vec[1].data[1] = 128'h00000000_000000BB_00000000_00000000;
    // order error 5 then 3
    vec[2].n = 4'd2; vec[2].nl = 2'd1; vec[2].addr[0] = 64'h10; vec[2].err = 1'b1;
    vec[2].idx[0] = 5; vec[2].val[0] = 32'h55; vec[2].idx[1] = 3; vec[2].val[1] = 32'h33;
    vec[2].data[0] = 128'h00000000_00000000_00000055_00000000;
    // line change onto a last slot
    vec[3].n = 4'd2; vec[3].nl = 2'd2; vec[3].addr[0] = 64'h0; vec[3].addr[1] = 64'h10;
    vec[3].idx[0] = 2; vec[3].val[0] = 32'hA2; vec[3].idx[1] = 7; vec[3].val[1] = 32'hB7;
    vec[3].data[0] = 128'h00000000_000000A2_00000000_00000000;
    vec[3].data[1] = 128'h000000B7_00000000_00000000_00000000;
    // single element in line 2
    vec[4].n = 4'd1; vec[4].nl = 2'd1; vec[4].addr[0] = 64'h20;
    vec[4].idx[0] = 9; vec[4].val[0] = 32'h99;
    vec[4].data[0] = 128'h00000000_00000000_00000099_00000000;

    bus_a.elem_valid = 1'b0; bus_a.elem_index = '0; bus_a.elem_value = '0;
    bus_a.wr_ready = 1'b1; bus_a.wr_rsp = 1'b0;
    bus_b.elem_valid = 1'b0; bus_b.elem_index = '0; bus_b.elem_value = '0;
    bus_b.wr_ready = 1'b1; bus_b.wr_rsp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_valid", bus_a.wr_valid, 1'b0);
    chk("rst_elem_ready", bus_a.elem_ready, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_addr", bus_a.wr_addr, 64'h0);
    chk("rst_data", bus_a.wr_data, 128'h0);
    chk("rst_lw", lw_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 5; c++) run_case(vec[c], 1'b0);
    run_case(vec[0], 1'b1);

    // Reset while a line is waiting on the write master.
    start_a = 1'b1; @(negedge clk); start_a = 1'b0; @(negedge clk);
    bus_a.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(i, 32'h10 + i);
    chk("pre_rst_wr_valid", bus_a.wr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_valid", bus_a.wr_valid, 1'b0);
    chk("mid_rst_elem_ready", bus_a.elem_ready, 1'b0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_err", err_a, 1'b0);
    chk("mid_rst_addr", bus_a.wr_addr, 64'h0);
    chk("mid_rst_data", bus_a.wr_data, 128'h0);
    chk("mid_rst_lw", lw_a, 32'd0);
    @(negedge clk); rst_n = 1'b1; bus_a.wr_ready = 1'b1; @(negedge clk);
    run_case(vec[0], 1'b0);

    // Outstanding limit of 2 with responses withheld.
    start_b = 1'b1; @(negedge clk); start_b = 1'b0; @(negedge clk);
    for (int i = 0; i < 12; i++) send_b(i, 32'h10 + i);
    bus_b.elem_valid = 1'b1; bus_b.elem_index = 12; bus_b.elem_value = 32'h1C;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("lim_wr_valid", bus_b.wr_valid, 1'b0);
      chk("lim_elem_ready", bus_b.elem_ready, 1'b0);
      chk("lim_lw", lw_b, 32'd2);
      @(negedge clk);
    end
    chk("lim_issued", qb_addr.size(), 2);
    bus_b.wr_rsp = 1'b1; @(negedge clk); bus_b.wr_rsp = 1'b0; @(negedge clk);
    chk("lim_release_cnt", qb_addr.size(), 3);
    chk("lim_release_lw", lw_b, 32'd3);
    if (qb_addr.size() >= 3) begin
      chk("lim_release_addr", qb_addr[2], 64'h20);
      chk("lim_release_data", qb_data[2], 128'h0000001B_0000001A_00000019_00000018);
    end
    for (int i = 12; i < 16; i++) send_b(i, 32'h10 + i);
    flush_b = 1'b1; @(negedge clk); flush_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_b.wr_rsp = 1'b1; @(negedge clk); bus_b.wr_rsp = 1'b0; @(negedge clk);
    end
    b = 0;
    while (done_cnt_b == 0 && b < 20) begin @(negedge clk); b++; end
    if (b >= 20) timeout("lim_done");
    chk("lim_done_cnt", done_cnt_b, 1);
    chk("lim_final_lw", lw_b, 32'd4);
    chk("lim_final_cnt", qb_addr.size(), 4);
    if (qb_addr.size() >= 4) chk("lim_final_addr", qb_addr[3], 64'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
